game_hit_resolver: RTL and testbench

//  Consumes per-frame collision flags from the collision stage and applies their consequences to game state.

---
 rtl/game_hit_resolver.sv | 229 ++++++++++++++++++++++
 tb/tb_game_hit_resolver.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_hit_resolver.sv
// game_hit_resolver
//   Applies the per-frame collision flags to game state: per-enemy HP and
//   alive bits, bullet kill pulses, player lives, the post-hit invincibility
//   window, score, and the round state machine (IDLE/PLAY/OVER/CLEAR).
//   Frame ticks are processed only in PLAY; i_GameStart (re)starts a round
//   from any other state.
// Ports
//   i_Clk, i_Rst_n        clock, asynchronous active-low reset
//   i_FrameTick           1-cycle frame strobe; collision flags valid with it
//   i_GameStart           start/restart request
//   i_EnemyHit            enemy n hit by a player bullet
//   i_PlayerBulletHit     player bullet k collided
//   i_EnemyBulletHit      enemy bullet i collided
//   i_PlayerHit           player hit by an enemy bullet
//   i_EnemySpawn          respawn request per enemy slot
//   o_EnemyAlive          enemy slot active
//   o_EnemyKill           1-cycle pulse per destroyed enemy
//   o_PlayerBulletKill    1-cycle pulse freeing player bullet slots
//   o_EnemyBulletKill     1-cycle pulse freeing enemy bullet slots
//   o_Lives               remaining lives
//   o_Invincible          invincibility window active
//   o_Score               saturating score
//   o_State               0 IDLE, 1 PLAY, 2 OVER, 3 CLEAR

// One enemy slot: HP counter, alive bit and registered kill pulse.
// o_AliveNext / o_KillNext expose the next-state values so the top can
// detect a cleared field and score kills in the same frame.
module game_hit_resolver_slot #(
    parameter int ENEMY_HP = 3,
    parameter int HP_W     = 2
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Init,
    input  logic i_Frame,
    input  logic i_Hit,
    input  logic i_Spawn,
    output logic o_Alive,
    output logic o_AliveNext,
    output logic o_KillNext,
    output logic o_Kill
);
    logic [HP_W-1:0] hp_q, hp_d;
    logic            alive_q, alive_d;
    logic            kill_q, kill_d;

    always_comb begin
        hp_d    = hp_q;
        alive_d = alive_q;
        kill_d  = 1'b0;
        if (i_Init) begin
            alive_d = 1'b1;
            hp_d    = HP_W'(ENEMY_HP);
        end else if (i_Frame) begin
            if (alive_q) begin
                // A spawn on a live slot is dropped, even if this hit kills it.
                if (i_Hit) begin
                    if (hp_q == HP_W'(1)) begin
                        alive_d = 1'b0;
                        hp_d    = '0;
                        kill_d  = 1'b1;
                    end else begin
                        hp_d = hp_q - HP_W'(1);
                    end
                end
            end else if (i_Spawn) begin
                alive_d = 1'b1;
                hp_d    = HP_W'(ENEMY_HP);
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            hp_q    <= '0;
            alive_q <= 1'b0;
            kill_q  <= 1'b0;
        end else begin
            hp_q    <= hp_d;
            alive_q <= alive_d;
            kill_q  <= kill_d;
        end
    end

    assign o_Alive     = alive_q;
    assign o_AliveNext = alive_d;
    assign o_KillNext  = kill_d;
    assign o_Kill      = kill_q;
endmodule

module game_hit_resolver #(
    parameter int MAX_ENEMY         = 4,
    parameter int MAX_PLAYER_BULLET = 4,
    parameter int MAX_ENEMY_BULLET  = 8,
    parameter int ENEMY_HP          = 3,
    parameter int PLAYER_LIVES      = 3,
    parameter int INVINCIBLE_FRAMES = 60,
    parameter int SCORE_PER_KILL    = 10,
    parameter int SCORE_W           = 16
) (
    input  logic                         i_Clk,
    input  logic                         i_Rst_n,
    input  logic                         i_FrameTick,
    input  logic                         i_GameStart,
    input  logic [MAX_ENEMY-1:0]         i_EnemyHit,
    input  logic [MAX_PLAYER_BULLET-1:0] i_PlayerBulletHit,
    input  logic [MAX_ENEMY_BULLET-1:0]  i_EnemyBulletHit,
    input  logic                         i_PlayerHit,
    input  logic [MAX_ENEMY-1:0]         i_EnemySpawn,
    output logic [MAX_ENEMY-1:0]         o_EnemyAlive,
    output logic [MAX_ENEMY-1:0]         o_EnemyKill,
    output logic [MAX_PLAYER_BULLET-1:0] o_PlayerBulletKill,
    output logic [MAX_ENEMY_BULLET-1:0]  o_EnemyBulletKill,
    output logic [2:0]                   o_Lives,
    output logic                         o_Invincible,
    output logic [SCORE_W-1:0]           o_Score,
    output logic [1:0]                   o_State
);
    localparam int HP_W  = $clog2(ENEMY_HP + 1);
    localparam int KC_W  = $clog2(MAX_ENEMY + 1);
    // Headroom so score + kills*SCORE_PER_KILL never wraps before saturation.
    localparam int SUM_W = SCORE_W + 16;
    localparam logic [SUM_W-1:0] SCORE_MAX = {{16{1'b0}}, {SCORE_W{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_OVER  = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic [2:0]                   lives_q, lives_d;
    logic [7:0]                   inv_q, inv_d;
    logic [SCORE_W-1:0]           score_q, score_d;
    logic [MAX_PLAYER_BULLET-1:0] pbk_q, pbk_d;
    logic [MAX_ENEMY_BULLET-1:0]  ebk_q, ebk_d;

    logic                 start_go, frame_go;
    logic [MAX_ENEMY-1:0] alive, alive_nxt, kill_nxt, kill;
    logic [KC_W-1:0]      kill_cnt;
    logic [SUM_W-1:0]     score_sum;

    // Start is only honoured outside PLAY; since frames are only processed
    // in PLAY, a coincident start+tick never processes that frame.
    assign start_go = i_GameStart && (state_q != S_PLAY);
    assign frame_go = i_FrameTick && (state_q == S_PLAY);

    for (genvar n = 0; n < MAX_ENEMY; n++) begin : g_slot
        game_hit_resolver_slot #(
            .ENEMY_HP (ENEMY_HP),
            .HP_W     (HP_W)
        ) u_slot (
            .i_Clk       (i_Clk),
            .i_Rst_n     (i_Rst_n),
            .i_Init      (start_go),
            .i_Frame     (frame_go),
            .i_Hit       (i_EnemyHit[n]),
            .i_Spawn     (i_EnemySpawn[n]),
            .o_Alive     (alive[n]),
            .o_AliveNext (alive_nxt[n]),
            .o_KillNext  (kill_nxt[n]),
            .o_Kill      (kill[n])
        );
    end

    always_comb begin
        kill_cnt = '0;
        for (int n = 0; n < MAX_ENEMY; n++) begin
            kill_cnt = kill_cnt + KC_W'(kill_nxt[n]);
        end
        score_sum = {{16{1'b0}}, score_q} + SUM_W'(kill_cnt) * SUM_W'(SCORE_PER_KILL);
    end

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        inv_d   = inv_q;
        score_d = score_q;
        pbk_d   = '0;
        ebk_d   = '0;
        if (start_go) begin
            state_d = S_PLAY;
            lives_d = 3'(PLAYER_LIVES);
            inv_d   = '0;
            score_d = '0;
        end else if (frame_go) begin
            pbk_d   = i_PlayerBulletHit;
            ebk_d   = i_EnemyBulletHit;
            score_d = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
            if (inv_q != 8'd0) begin
                inv_d = inv_q - 8'd1;
            end else if (i_PlayerHit) begin
                lives_d = lives_q - 3'd1;
                if (lives_d != 3'd0) inv_d = 8'(INVINCIBLE_FRAMES);
            end
            // Losing the last life outranks clearing the field.
            if (lives_d == 3'd0)          state_d = S_OVER;
            else if (alive_nxt == '0)     state_d = S_CLEAR;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= S_IDLE;
            lives_q <= '0;
            inv_q   <= '0;
            score_q <= '0;
            pbk_q   <= '0;
            ebk_q   <= '0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            inv_q   <= inv_d;
            score_q <= score_d;
            pbk_q   <= pbk_d;
            ebk_q   <= ebk_d;
        end
    end

    assign o_EnemyAlive       = alive;
    assign o_EnemyKill        = kill;
    assign o_PlayerBulletKill = pbk_q;
    assign o_EnemyBulletKill  = ebk_q;
    assign o_Lives            = lives_q;
    assign o_Invincible       = (inv_q != 8'd0);
    assign o_Score            = score_q;
    assign o_State            = state_q;
endmodule

// File: tb/tb_game_hit_resolver.sv
// Directed bench for game_hit_resolver: a vector table for the main frame
// behaviour, then hand sequences for the invincibility window, game over,
// clear, mid-game reset and score saturation.
module tb_game_hit_resolver;
    logic        i_Clk = 1'b0;
    logic        i_Rst_n = 1'b0;
    logic        i_FrameTick = 1'b0, i_GameStart = 1'b0, i_PlayerHit = 1'b0;
    logic [3:0]  i_EnemyHit = '0, i_PlayerBulletHit = '0, i_EnemySpawn = '0;
    logic [7:0]  i_EnemyBulletHit = '0;
    logic [3:0]  o_EnemyAlive, o_EnemyKill, o_PlayerBulletKill;
    logic [7:0]  o_EnemyBulletKill;
    logic [2:0]  o_Lives;
    logic        o_Invincible;
    logic [15:0] o_Score;
    logic [1:0]  o_State;

    int n_cmp = 0;
    int n_err = 0;

    game_hit_resolver dut (
        .i_Clk              (i_Clk),
        .i_Rst_n            (i_Rst_n),
        .i_FrameTick        (i_FrameTick),
        .i_GameStart        (i_GameStart),
        .i_EnemyHit         (i_EnemyHit),
        .i_PlayerBulletHit  (i_PlayerBulletHit),
        .i_EnemyBulletHit   (i_EnemyBulletHit),
        .i_PlayerHit        (i_PlayerHit),
        .i_EnemySpawn       (i_EnemySpawn),
        .o_EnemyAlive       (o_EnemyAlive),
        .o_EnemyKill        (o_EnemyKill),
        .o_PlayerBulletKill (o_PlayerBulletKill),
        .o_EnemyBulletKill  (o_EnemyBulletKill),
        .o_Lives            (o_Lives),
        .o_Invincible       (o_Invincible),
        .o_Score            (o_Score),
        .o_State            (o_State)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic        st, tk;
        logic [3:0]  eh, pb;
        logic [7:0]  eb;
        logic        ph;
        logic [3:0]  sp;
        logic [3:0]  alive, kill, pbk;
        logic [7:0]  ebk;
        logic [2:0]  lives;
        logic        inv;
        logic [15:0] score;
        logic [1:0]  state;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(logic st, logic tk, logic [3:0] eh, logic [3:0] pb,
                               logic [7:0] eb, logic ph, logic [3:0] sp,
                               logic [3:0] alive, logic [3:0] kill, logic [3:0] pbk,
                               logic [7:0] ebk, logic [2:0] lives, logic inv,
                               logic [15:0] score, logic [1:0] state);
        vec_t r;
        r.st = st; r.tk = tk; r.eh = eh; r.pb = pb; r.eb = eb; r.ph = ph; r.sp = sp;
        r.alive = alive; r.kill = kill; r.pbk = pbk; r.ebk = ebk;
        r.lives = lives; r.inv = inv; r.score = score; r.state = state;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Apply inputs for one cycle; returns #1 after the edge with inputs cleared.
    task automatic cyc(logic st, logic tk, logic [3:0] eh, logic [3:0] pb,
                       logic [7:0] eb, logic ph, logic [3:0] sp);
        i_GameStart = st; i_FrameTick = tk; i_EnemyHit = eh; i_PlayerBulletHit = pb;
        i_EnemyBulletHit = eb; i_PlayerHit = ph; i_EnemySpawn = sp;
        @(posedge i_Clk);
        #1;
        i_GameStart = 0; i_FrameTick = 0; i_EnemyHit = '0; i_PlayerBulletHit = '0;
        i_EnemyBulletHit = '0; i_PlayerHit = 0; i_EnemySpawn = '0;
    endtask

    task automatic tick(logic [3:0] eh, logic [3:0] sp);
        cyc(0, 1, eh, 4'h0, 8'h00, 0, sp);
    endtask

    initial begin
        // reset / idle
        vq.push_back(v(0,0,4'h0,4'h0,8'h00,0,4'h0, 4'h0,4'h0,4'h0,8'h00,0,0,0,0));
        vq.push_back(v(0,1,4'hF,4'hF,8'hFF,1,4'hF, 4'h0,4'h0,4'h0,8'h00,0,0,0,0));
        // start
        vq.push_back(v(1,0,4'h0,4'h0,8'h00,0,4'h0, 4'hF,4'h0,4'h0,8'h00,3,0,0,1));
        // three hits on enemy 0
        vq.push_back(v(0,1,4'h1,4'h1,8'h00,0,4'h0, 4'hF,4'h0,4'h1,8'h00,3,0,0,1));
        vq.push_back(v(0,1,4'h1,4'h0,8'h00,0,4'h0, 4'hF,4'h0,4'h0,8'h00,3,0,0,1));
        vq.push_back(v(0,1,4'h1,4'h0,8'h00,0,4'h0, 4'hE,4'h1,4'h0,8'h00,3,0,10,1));
        vq.push_back(v(0,0,4'h0,4'h0,8'h00,0,4'h0, 4'hE,4'h0,4'h0,8'h00,3,0,10,1));
        // hit on a dead slot ignored
        vq.push_back(v(0,1,4'h1,4'h0,8'h00,0,4'h0, 4'hE,4'h0,4'h0,8'h00,3,0,10,1));
        // respawn slot 0; spawn+hit on live slot 1 -> hp 2, no refill
        vq.push_back(v(0,1,4'h2,4'h0,8'h00,0,4'h3, 4'hF,4'h0,4'h0,8'h00,3,0,10,1));
        vq.push_back(v(0,1,4'h3,4'h0,8'h00,0,4'h0, 4'hF,4'h0,4'h0,8'h00,3,0,10,1));
        vq.push_back(v(0,1,4'h3,4'h0,8'h00,0,4'h0, 4'hD,4'h2,4'h0,8'h00,3,0,20,1));
        vq.push_back(v(0,1,4'h1,4'h0,8'h00,0,4'h0, 4'hC,4'h1,4'h0,8'h00,3,0,30,1));
        // start ignored while playing
        vq.push_back(v(1,0,4'h0,4'h0,8'h00,0,4'h0, 4'hC,4'h0,4'h0,8'h00,3,0,30,1));
        // player hit -> lives 2, invincible
        vq.push_back(v(0,1,4'h0,4'h0,8'h81,1,4'h0, 4'hC,4'h0,4'h0,8'h81,2,1,30,1));
        for (int i = 0; i < 4; i++)
            vq.push_back(v(0,1,4'h0,4'h0,8'h00,0,4'h0, 4'hC,4'h0,4'h0,8'h00,2,1,30,1));
        // hit 5 ticks later ignored, bullet still freed
        vq.push_back(v(0,1,4'h0,4'h0,8'h02,1,4'h0, 4'hC,4'h0,4'h0,8'h02,2,1,30,1));

        #2;
        i_Rst_n = 1'b1;
        @(posedge i_Clk);
        #1;
        for (int i = 0; i < vq.size(); i++) begin
            cyc(vq[i].st, vq[i].tk, vq[i].eh, vq[i].pb, vq[i].eb, vq[i].ph, vq[i].sp);
            chk($sformatf("v%0d.alive", i), 32'(o_EnemyAlive), 32'(vq[i].alive));
            chk($sformatf("v%0d.kill", i), 32'(o_EnemyKill), 32'(vq[i].kill));
            chk($sformatf("v%0d.pbk", i), 32'(o_PlayerBulletKill), 32'(vq[i].pbk));
            chk($sformatf("v%0d.ebk", i), 32'(o_EnemyBulletKill), 32'(vq[i].ebk));
            chk($sformatf("v%0d.lives", i), 32'(o_Lives), 32'(vq[i].lives));
            chk($sformatf("v%0d.inv", i), 32'(o_Invincible), 32'(vq[i].inv));
            chk($sformatf("v%0d.score", i), 32'(o_Score), 32'(vq[i].score));
            chk($sformatf("v%0d.state", i), 32'(o_State), 32'(vq[i].state));
        end

        // window ends on the 60th tick after the hit (5 already taken)
        for (int i = 0; i < 54; i++) tick(4'h0, 4'h0);
        chk("inv_tick59", 32'(o_Invincible), 1);
        tick(4'h0, 4'h0);
        chk("inv_tick60", 32'(o_Invincible), 0);

        // second life lost, then wait out the window
        cyc(0, 1, 4'h0, 4'h0, 8'h00, 1, 4'h0);
        chk("lives_1", 32'(o_Lives), 1);
        chk("inv_again", 32'(o_Invincible), 1);
        for (int i = 0; i < 60; i++) tick(4'h0, 4'h0);
        chk("inv_off2", 32'(o_Invincible), 0);

        // last enemies and last life in the same frame -> OVER, score still adds
        tick(4'hC, 4'h0);
        tick(4'hC, 4'h0);
        chk("pre_over_alive", 32'(o_EnemyAlive), 32'hC);
        cyc(0, 1, 4'hC, 4'h0, 8'h00, 1, 4'h0);
        chk("over_state", 32'(o_State), 2);
        chk("over_lives", 32'(o_Lives), 0);
        chk("over_score", 32'(o_Score), 50);
        chk("over_kill", 32'(o_EnemyKill), 32'hC);
        chk("over_alive", 32'(o_EnemyAlive), 0);
        cyc(0, 1, 4'h0, 4'h3, 8'h00, 0, 4'h0);
        chk("over_kill_drop", 32'(o_EnemyKill), 0);
        chk("over_no_pbk", 32'(o_PlayerBulletKill), 0);

        // start + tick together: restart wins, frame dropped
        cyc(1, 1, 4'hF, 4'h5, 8'h00, 0, 4'h0);
        chk("restart_state", 32'(o_State), 1);
        chk("restart_lives", 32'(o_Lives), 3);
        chk("restart_score", 32'(o_Score), 0);
        chk("restart_alive", 32'(o_EnemyAlive), 32'hF);
        chk("restart_pbk", 32'(o_PlayerBulletKill), 0);

        // kill everything -> CLEAR
        tick(4'hF, 4'h0);
        tick(4'hF, 4'h0);
        tick(4'hF, 4'h0);
        chk("clear_state", 32'(o_State), 3);
        chk("clear_score", 32'(o_Score), 40);
        chk("clear_kill", 32'(o_EnemyKill), 32'hF);
        cyc(0, 1, 4'h0, 4'h0, 8'hFF, 0, 4'h0);
        chk("clear_no_ebk", 32'(o_EnemyBulletKill), 0);
        cyc(1, 0, 4'h0, 4'h0, 8'h00, 0, 4'h0);
        chk("clear_restart", 32'(o_State), 1);

        // reset while a tick is pending, before its edge
        i_FrameTick = 1; i_PlayerBulletHit = 4'h1;
        #2 i_Rst_n = 1'b0;
        @(posedge i_Clk);
        #1;
        chk("rst_pre_pbk", 32'(o_PlayerBulletKill), 0);
        chk("rst_pre_state", 32'(o_State), 0);
        chk("rst_pre_alive", 32'(o_EnemyAlive), 0);
        i_FrameTick = 0; i_PlayerBulletHit = '0;
        i_Rst_n = 1'b1;
        cyc(1, 0, 4'h0, 4'h0, 8'h00, 0, 4'h0);
        // reset during a live pulse cancels it
        cyc(0, 1, 4'h0, 4'h2, 8'h00, 0, 4'h0);
        chk("pulse_live", 32'(o_PlayerBulletKill), 32'h2);
        i_Rst_n = 1'b0;
        #1;
        chk("rst_mid_pbk", 32'(o_PlayerBulletKill), 0);
        chk("rst_mid_state", 32'(o_State), 0);
        chk("rst_mid_lives", 32'(o_Lives), 0);
        @(negedge i_Clk);
        i_Rst_n = 1'b1;
        @(posedge i_Clk);
        #1;

        // grind the score up to 65530, slot 3 kept alive to avoid CLEAR
        cyc(1, 0, 4'h0, 4'h0, 8'h00, 0, 4'h0);
        for (int r = 0; r < 2184; r++) begin
            tick(4'h7, 4'h0);
            tick(4'h7, 4'h0);
            tick(4'h7, 4'h0);
            tick(4'h0, 4'h7);
        end
        chk("grind_score", 32'(o_Score), 65520);
        chk("grind_state", 32'(o_State), 1);
        tick(4'h1, 4'h0);
        tick(4'h1, 4'h0);
        tick(4'h1, 4'h0);
        chk("score_65530", 32'(o_Score), 65530);
        tick(4'h0, 4'h1);
        tick(4'h1, 4'h0);
        tick(4'h1, 4'h0);
        tick(4'h1, 4'h0);
        chk("score_sat", 32'(o_Score), 65535);
        tick(4'h0, 4'h1);
        tick(4'h3, 4'h0);
        tick(4'h3, 4'h0);
        tick(4'h3, 4'h0);
        chk("score_sat_hold", 32'(o_Score), 65535);
        chk("sat_kill", 32'(o_EnemyKill), 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
